gcd_issue: RTL

GCD_ISSUE -- requirements
Module: gcd_issue

---
 rtl/gcd_issue_pkg.sv | 18 +
 rtl/gcd_issue_if.sv | 32 +++
 rtl/gcd_fifo.sv | 59 +++++
 rtl/gcd_issue.sv | 111 +++++++++++
 4 files changed

// File: rtl/gcd_issue_pkg.sv
// Shared types and constants for the GCD operand-issue block.
// Holds the controller state type, the cycle-counter width and a saturating increment.
package gcd_issue_pkg;

    localparam int CYC_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } issue_state_t;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

endpackage

// File: rtl/gcd_issue_if.sv
// Operand, core and result signals of gcd_issue bundled into one interface.
// slave is the gcd_issue side, master is the producer/core/consumer side.
interface gcd_issue_if #(
    parameter int XLEN = 16
) ();
    import gcd_issue_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_a;
    logic [XLEN-1:0]   in_b;
    logic              ld_o;
    logic [XLEN-1:0]   a_o;
    logic [XLEN-1:0]   b_o;
    logic              core_done_i;
    logic [XLEN-1:0]   core_gcd_i;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_gcd;
    logic [CYC_W-1:0]  out_cycles;

    modport slave (
        input  in_valid, in_a, in_b, core_done_i, core_gcd_i, out_ready,
        output in_ready, ld_o, a_o, b_o, out_valid, out_gcd, out_cycles
    );

    modport master (
        output in_valid, in_a, in_b, core_done_i, core_gcd_i, out_ready,
        input  in_ready, ld_o, a_o, b_o, out_valid, out_gcd, out_cycles
    );

endinterface

// File: rtl/gcd_fifo.sv
// First-word-fall-through operand FIFO with wrap-around pointers.
// Full is reported from the registered count, so a pop never opens a slot in the same cycle.
module gcd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gcd_issue.sv
// Queues operand pairs and issues them one at a time to an external GCD core,
// returning each result with the number of cycles the core took.
module gcd_issue
    import gcd_issue_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    gcd_issue_if.slave  bus
);
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [2*XLEN-1:0]   head;
    logic [XLEN-1:0]     head_a;
    logic [XLEN-1:0]     head_b;
    logic                bypass;
    logic                ld;

    issue_state_t        state_q, state_d;
    logic [CYC_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     gcd_q, gcd_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;

    gcd_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.in_valid),
        .data_i  ({bus.in_a, bus.in_b}),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (head)
    );

    assign head_a = head[2*XLEN-1:XLEN];
    assign head_b = head[XLEN-1:0];
    // A zero operand makes the GCD the other operand, so the core is skipped.
    assign bypass = (head_a == '0) || (head_b == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gcd_d    = gcd_q;
        cyc_d    = cyc_q;
        fifo_pop = 1'b0;
        ld       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fifo_pop = 1'b1;
                if (bypass) begin
                    gcd_d   = head_a | head_b;
                    cyc_d   = '0;
                    state_d = HOLD;
                end else begin
                    ld      = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The captured count includes the cycle on which done arrives.
                cnt_d = sat_inc(cnt_q);
                if (bus.core_done_i) begin
                    gcd_d   = bus.core_gcd_i;
                    cyc_d   = sat_inc(cnt_q);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = fifo_empty ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gcd_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            cyc_q   <= cyc_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.ld_o       = ld;
    assign bus.a_o        = head_a;
    assign bus.b_o        = head_b;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_gcd    = gcd_q;
    assign bus.out_cycles = cyc_q;

endmodule
